// File: rtl/signed_divider_pkg.sv
// Shared types and sizing helpers for the multi-cycle signed divider.
package signed_divider_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter must hold values 0..width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module divider_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH:0]   divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] partial_c;
  logic [WIDTH:0] diff_c;

  // The partial remainder always fits WIDTH bits afterwards except for a
  // zero divisor, whose remainder is rebuilt from the stored dividend.
  always_comb begin
    partial_c = {rem_i, quot_i[WIDTH-1]};
    diff_c    = partial_c - divisor_i;
    if (partial_c >= divisor_i) begin
      rem_o  = WIDTH'(diff_c);
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = WIDTH'(partial_c);
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/signed_divider.sv
// Multi-cycle signed divider with start/done handshake.
// Optional: SIGNED_DIVIDER_DIVZERO_FAST_EN lets a zero divisor skip the BUSY phase.
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     Ain,
  input  logic [WIDTH-1:0]     Bin,
  input  logic                 start,
  output logic                 DivWait,
  output logic                 writeResultSig,
  output logic [WIDTH-1:0]     result,
  output logic [2*WIDTH-1:0]   remainder
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned RW = 2 * WIDTH;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   a_abs_q, a_abs_d;
  logic [AW-1:0]   b_abs_q, b_abs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic            sgn_quot_q, sgn_quot_d;
  logic            sgn_rem_q, sgn_rem_d;
  logic            busy_q, busy_d;
  logic            wr_q, wr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [RW-1:0]   remainder_q, remainder_d;

  logic [AW-1:0]    a_ext_c, b_ext_c, a_abs_c, b_abs_c;
  logic [RW-1:0]    rem_mag_c;
  logic [WIDTH-1:0] step_rem_c, step_quot_c;

  // Magnitudes carry one extra bit so the most negative operand is exact.
  always_comb begin
    a_ext_c = {Ain[WIDTH-1], Ain};
    b_ext_c = {Bin[WIDTH-1], Bin};
    a_abs_c = Ain[WIDTH-1] ? (~a_ext_c + AW'(1)) : a_ext_c;
    b_abs_c = Bin[WIDTH-1] ? (~b_ext_c + AW'(1)) : b_ext_c;
  end

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (b_abs_q),
    .rem_o     (step_rem_c),
    .quot_o    (step_quot_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_abs_q     <= '0;
      b_abs_q     <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      sgn_quot_q  <= 1'b0;
      sgn_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_q        <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_abs_q     <= a_abs_d;
      b_abs_q     <= b_abs_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      sgn_quot_q  <= sgn_quot_d;
      sgn_rem_q   <= sgn_rem_d;
      busy_q      <= busy_d;
      wr_q        <= wr_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_abs_d     = a_abs_q;
    b_abs_d     = b_abs_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    sgn_quot_d  = sgn_quot_q;
    sgn_rem_d   = sgn_rem_q;
    wr_d        = 1'b0;
    result_d    = result_q;
    remainder_d = remainder_q;
    rem_mag_c   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_abs_d    = a_abs_c;
          b_abs_d    = b_abs_c;
          rem_d      = '0;
          quot_d     = a_abs_c[WIDTH-1:0];
          cnt_d      = '0;
          sgn_quot_d = Ain[WIDTH-1] ^ Bin[WIDTH-1];
          sgn_rem_d  = Ain[WIDTH-1];
`ifdef SIGNED_DIVIDER_DIVZERO_FAST_EN
          state_d    = (Bin == '0) ? DONE : BUSY;
`else
          state_d    = BUSY;
`endif
        end
      end

      BUSY: begin
        rem_d  = step_rem_c;
        quot_d = step_quot_c;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
        wr_d    = 1'b1;
        // A zero divisor reports -1 and hands the dividend back as remainder.
        if (b_abs_q == '0) begin
          result_d  = '1;
          rem_mag_c = RW'(a_abs_q);
        end else begin
          result_d  = sgn_quot_q ? (~quot_q + WIDTH'(1)) : quot_q;
          rem_mag_c = RW'(rem_q);
        end
        remainder_d = sgn_rem_q ? (~rem_mag_c + RW'(1)) : rem_mag_c;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == BUSY);
  end

  assign DivWait        = busy_q;
  assign writeResultSig = wr_q;
  assign result         = result_q;
  assign remainder      = remainder_q;

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider (WIDTH=8) against an integer-arithmetic model.
module tb_signed_divider;

  logic        clk;
  logic        rst_n;
  logic [7:0]  Ain;
  logic [7:0]  Bin;
  logic        start;
  logic        DivWait;
  logic        writeResultSig;
  logic [7:0]  result;
  logic [15:0] remainder;

  int errors = 0;
  int checks = 0;

  signed_divider #(.WIDTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Ain            (Ain),
    .Bin            (Bin),
    .start          (start),
    .DivWait        (DivWait),
    .writeResultSig (writeResultSig),
    .result         (result),
    .remainder      (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: C-style truncating division; divide-by-zero yields -1 / dividend.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [15:0] r);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = 8'hFF;
      r = 16'(sa);
    end else begin
      q = 8'(sa / sb);
      r = 16'(sa % sb);
    end
  endtask

  task automatic do_div(input logic [7:0] a, input logic [7:0] b, input bit repulse);
    logic [7:0]  exp_q, got_q;
    logic [15:0] exp_r, got_r;
    int exp_lat, exp_wait, wait_cnt, wr_cnt, wr_at;
    model(a, b, exp_q, exp_r);
    exp_lat  = 9;
    exp_wait = 8;
`ifdef SIGNED_DIVIDER_DIVZERO_FAST_EN
    if (b == 8'd0) begin
      exp_lat  = 1;
      exp_wait = 0;
    end
`endif
    got_q = 'x;
    got_r = 'x;
    wait_cnt = 0;
    wr_cnt   = 0;
    wr_at    = -1;
    Ain = a;
    Bin = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    Ain = 8'($urandom);
    Bin = 8'($urandom);
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (repulse && k == 3) begin
        start = 1'b1;
        Ain = 8'($urandom);
        Bin = 8'($urandom_range(1, 255));
      end
      if (repulse && k == 4) start = 1'b0;
      if (DivWait) wait_cnt++;
      if (writeResultSig) begin
        wr_cnt++;
        if (wr_at < 0) begin
          wr_at = k;
          got_q = result;
          got_r = remainder;
        end
      end
    end
    check("wr_pulses", 32'(wr_cnt), 32'd1);
    check("wr_latency", 32'(wr_at), 32'(exp_lat));
    check("divwait_cycles", 32'(wait_cnt), 32'(exp_wait));
    check("result", 32'(got_q), 32'(exp_q));
    check("remainder", 32'(got_r), 32'(exp_r));
    check("result_hold", 32'(result), 32'(exp_q));
  endtask

  initial begin
    logic [7:0]  q1, q2;
    logic [15:0] r1, r2;
    int wr_cnt;

    rst_n = 1'b0;
    start = 1'b0;
    Ain   = 8'd0;
    Bin   = 8'd0;
    #3;
    check("rst_divwait", 32'(DivWait), 32'd0);
    check("rst_wr", 32'(writeResultSig), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_div(8'd90, 8'd40, 1'b0);
    do_div(8'($signed(-90)), 8'd40, 1'b0);
    do_div(8'd90, 8'($signed(-40)), 1'b0);
    do_div(8'h80, 8'hFF, 1'b0);
    do_div(8'h80, 8'd7, 1'b0);
    do_div(8'd55, 8'd0, 1'b0);
    do_div(8'($signed(-55)), 8'd0, 1'b0);
    do_div(8'h80, 8'd0, 1'b0);
    do_div(8'd127, 8'h80, 1'b0);
    do_div(8'd0, 8'd5, 1'b0);
    do_div(8'd7, 8'd127, 1'b0);
    do_div(8'd100, 8'd3, 1'b1);

    for (int i = 0; i < 20; i++) begin
      do_div(8'($urandom), 8'($urandom), 1'b0);
    end

    // start held high: second division launches on the IDLE cycle after DONE.
    model(8'd77, 8'd6, q1, r1);
    model(8'($signed(-100)), 8'd9, q2, r2);
    Ain = 8'd77;
    Bin = 8'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    Ain = 8'($signed(-100));
    Bin = 8'd9;
    wr_cnt = 0;
    for (int k = 1; k <= 19; k++) begin
      @(posedge clk);
      #1;
      if (writeResultSig) wr_cnt++;
      if (k == 9) begin
        check("held_wr1", 32'(writeResultSig), 32'd1);
        check("held_result1", 32'(result), 32'(q1));
        check("held_remainder1", 32'(remainder), 32'(r1));
      end
      if (k == 19) begin
        check("held_wr2", 32'(writeResultSig), 32'd1);
        check("held_result2", 32'(result), 32'(q2));
        check("held_remainder2", 32'(remainder), 32'(r2));
      end
    end
    start = 1'b0;
    check("held_wr_pulses", 32'(wr_cnt), 32'd2);
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-division aborts without a done pulse.
    Ain = 8'd100;
    Bin = 8'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_divwait", 32'(DivWait), 32'd0);
    check("abort_wr", 32'(writeResultSig), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk);
      #1;
      if (writeResultSig || DivWait) wr_cnt++;
    end
    check("abort_no_activity", 32'(wr_cnt), 32'd0);
    do_div(8'd100, 8'd7, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
